// File: rtl/line_buffer_reader.sv
// Ping-pong line buffer: the back bank takes renderer writes while the front bank
// streams one pixel index per clk and clears each entry behind it. Optional build
// macro LINEBUF_HSCALE2_EN enables horizontal 2x pixel doubling.
`timescale 1ns/1ps
module line_buffer_reader #(
  parameter int WIDTH = 640,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_of_screen,
  input  logic             start_of_line,
  input  logic [IDX_W-1:0] linebuf_wridx,
  input  logic [7:0]       linebuf_wrdata,
  input  logic             linebuf_wren,
  input  logic             display_active,
  input  logic [7:0]       border_color,
  output logic             pixel_valid,
  output logic [7:0]       pixel_data
);

  // One extra bit so the read pointer can park at WIDTH even when WIDTH == 2^IDX_W.
  localparam logic [IDX_W:0] LAST_X = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W:0] ONE_X  = (IDX_W+1)'(1);

  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W:0]   rd_x_q, rd_x_d;
  logic             valid_q;
  logic             src_ram_q, src_ram_d;
  logic [7:0]       hold_q, hold_d;
  logic             rd_sel_q, rd_sel_d;
  logic             rd_in_range;
  logic             rd_en;
  logic             wr_ok;
  logic             repeat_px;
  logic [7:0]       bank_dout [2];
  logic [7:0]       ram_dout;

`ifdef LINEBUF_HSCALE2_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (start_of_screen || start_of_line) begin
      phase_d = 1'b0;
    end else if (display_active) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign repeat_px = display_active & phase_q;
`else
  assign repeat_px = 1'b0;
`endif

  assign rd_in_range = (rd_x_q < LAST_X);
  assign rd_en       = display_active & ~repeat_px & rd_in_range;
  assign wr_ok       = linebuf_wren & ({1'b0, linebuf_wridx} < LAST_X);

  always_comb begin
    rd_bank_d = rd_bank_q;
    rd_x_d    = rd_x_q;
    if (start_of_screen) begin
      rd_bank_d = 1'b0;
      rd_x_d    = '0;
    end else if (start_of_line) begin
      rd_bank_d = ~rd_bank_q;
      rd_x_d    = '0;
    end else if (rd_en) begin
      rd_x_d    = rd_x_q + ONE_X;
    end
  end

  // The output is either the live RAM read register or a held/border byte, so the
  // RAM output register itself never needs a reset.
  always_comb begin
    src_ram_d = src_ram_q;
    hold_d    = hold_q;
    rd_sel_d  = rd_sel_q;
    if (rd_en) begin
      src_ram_d = 1'b1;
      rd_sel_d  = rd_bank_q;
    end else if (display_active && !repeat_px) begin
      src_ram_d = 1'b0;
      hold_d    = border_color;
    end else if (!display_active) begin
      src_ram_d = 1'b0;
      if (src_ram_q) begin
        hold_d = ram_dout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_q <= 1'b0;
      rd_x_q    <= '0;
      valid_q   <= 1'b0;
      src_ram_q <= 1'b0;
      hold_q    <= 8'h00;
      rd_sel_q  <= 1'b0;
    end else begin
      rd_bank_q <= rd_bank_d;
      rd_x_q    <= rd_x_d;
      valid_q   <= display_active;
      src_ram_q <= src_ram_d;
      hold_q    <= hold_d;
      rd_sel_q  <= rd_sel_d;
    end
  end

  // Each bank has one write port: clear-after-read while front, renderer while back.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [7:0]       mem [WIDTH];
      logic             is_front;
      logic             we;
      logic             re;
      logic [IDX_W-1:0] waddr;
      logic [7:0]       wdata;
      logic [7:0]       dout_q;

      assign is_front = (rd_bank_q == 1'(gi));
      assign re       = rd_en & is_front;
      assign we       = is_front ? rd_en : wr_ok;
      assign waddr    = is_front ? rd_x_q[IDX_W-1:0] : linebuf_wridx;
      assign wdata    = is_front ? 8'h00 : linebuf_wrdata;

      always_ff @(posedge clk) begin
        if (re) begin
          dout_q <= mem[rd_x_q[IDX_W-1:0]];
        end
        if (we) begin
          mem[waddr] <= wdata;
        end
      end

      assign bank_dout[gi] = dout_q;
    end
  endgenerate

  assign ram_dout    = rd_sel_q ? bank_dout[1] : bank_dout[0];
  assign pixel_valid = valid_q;
  assign pixel_data  = src_ram_q ? ram_dout : hold_q;

endmodule

// File: tb/tb_line_buffer_reader.sv
// Scoreboard bench for line_buffer_reader: a behavioural two-bank model predicts
// every output cycle; predictions are queued at drive time and popped at output time.
`timescale 1ns/1ps
module tb_line_buffer_reader;

  localparam int WIDTH = 640;
  localparam int IDX_W = 10;
`ifdef LINEBUF_HSCALE2_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  localparam int RD = HS ? 2 * WIDTH : WIDTH;
  localparam int SC = HS ? 2 : 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sos = 1'b0;
  logic             sol = 1'b0;
  logic             wren = 1'b0;
  logic             da = 1'b0;
  logic [IDX_W-1:0] wridx = '0;
  logic [7:0]       wrdata = 8'h00;
  logic [7:0]       border = 8'h00;
  logic             pixel_valid;
  logic [7:0]       pixel_data;

  always #5 clk = ~clk;

  line_buffer_reader #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start_of_screen (sos),
    .start_of_line   (sol),
    .linebuf_wridx   (wridx),
    .linebuf_wrdata  (wrdata),
    .linebuf_wren    (wren),
    .display_active  (da),
    .border_color    (border),
    .pixel_valid     (pixel_valid),
    .pixel_data      (pixel_data)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       v;
    logic [7:0] d;
    bit         care;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  logic [7:0] m_mem [2][WIDTH];
  bit         m_known [2][WIDTH];
  bit         m_bank;
  int         m_x;
  bit         m_phase;
  logic [7:0] m_last;
  bit         m_last_ok;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank = 1'b0;
    m_x = 0;
    m_phase = 1'b0;
    m_last = 8'h00;
    m_last_ok = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < WIDTH; i++) m_known[b][i] = 1'b0;
  endtask

  task automatic step(input bit s_sos, input bit s_sol, input bit s_wren,
                      input int s_idx, input logic [7:0] s_data, input bit s_da);
    exp_t e;
    @(posedge clk);
    #1;
    sos = s_sos; sol = s_sol; wren = s_wren;
    wridx = s_idx[IDX_W-1:0]; wrdata = s_data; da = s_da;
    if (s_da) begin
      if (HS && m_phase) begin
        // doubled pixel: output repeats
      end else if (m_x < WIDTH) begin
        m_last = m_mem[m_bank][m_x];
        m_last_ok = m_known[m_bank][m_x];
        m_mem[m_bank][m_x] = 8'h00;
        m_known[m_bank][m_x] = 1'b1;
        m_x++;
      end else begin
        m_last = border;
        m_last_ok = 1'b1;
      end
    end
    if (s_wren && s_idx < WIDTH) begin
      m_mem[!m_bank][s_idx] = s_data;
      m_known[!m_bank][s_idx] = 1'b1;
    end
    if (s_sos) begin
      m_bank = 1'b0; m_x = 0; m_phase = 1'b0;
    end else if (s_sol) begin
      m_bank = !m_bank; m_x = 0; m_phase = 1'b0;
    end else if (s_da && HS) begin
      m_phase = !m_phase;
    end
    e.c = cyc; e.v = s_da; e.d = m_last; e.care = m_last_ok;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].c == cyc - 1) begin
        e = sb.pop_front();
        check_val("valid", int'(pixel_valid), int'(e.v));
        if (e.care) check_val(e.v ? "pixel" : "hold", int'(pixel_data), int'(e.d));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d entries pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    check_val("rst_valid", int'(pixel_valid), 0);
    check_val("rst_data", int'(pixel_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fill line then read it back
    step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b0, 1'b1, i, 8'(i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < RD; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle(3);

    // Clear-after-read: both banks read once more without new writes
    for (int l = 0; l < 2; l++) begin
      step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
      for (int i = 0; i < RD; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
      idle(2);
    end

    // Border, ping-pong isolation, dropped write, write on the swap cycle
    border = 8'h2A;
    step(1'b0, 1'b1, 1'b1, 7, 8'h33, 1'b0);
    for (int i = 0; i < RD + 10 * SC; i++) begin
      if (i == 50)      step(1'b0, 1'b0, 1'b1, 5, 8'h77, 1'b1);
      else if (i == 60) step(1'b0, 1'b0, 1'b1, 700, 8'h55, 1'b1);
      else              step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    end
    idle(2);

    // Next line with display_active gaps; border value changes mid-stream
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < RD + 200; i++) begin
      if (i == RD) border = 8'hC5;
      step(1'b0, 1'b0, 1'b0, 0, 8'h00, (i % 5) != 2);
    end
    idle(2);

    // start_of_screen beats a coincident start_of_line
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3, 8'h99, 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 10 * SC; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a readout
    for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b0, 1'b1, i, 8'(i + 'h40), 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    @(posedge clk);
    #3;
    check_val("pre_rst_valid", int'(pixel_valid), 1);
    check_val("pre_rst_data", int'(pixel_data), int'(m_last));
    rst = 1'b1;
    #1;
    check_val("async_rst_valid", int'(pixel_valid), 0);
    check_val("async_rst_data", int'(pixel_data), 0);
    sb.delete();
    da = 1'b0; wren = 1'b0; sos = 1'b0; sol = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Short line after reset
    step(1'b1, 1'b0, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, i, 8'(8'hA0 + i), 1'b0);
    step(1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0);
    for (int i = 0; i < 8 * SC; i++) step(1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b1);
    idle(3);
    repeat (3) @(posedge clk);
    #1;
    check_val("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
